// File: rtl/mem_dbus_master.sv
// MEM-stage initiator for the SRAM-like data bus: issues one load/store at a time,
// stalls MEM until it completes, and drains transactions orphaned by a flush.
module mem_dbus_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Valid,
  input  logic              MEM_IsLoad,
  input  logic              MEM_IsStore,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [31:0]       MEM_StoreData,
  input  logic [1:0]        MEM_Size,
  input  logic              MEM_LoadSign,
  input  logic              MEM_Flush,
  input  logic              WB_Wr,
  output logic              MEM_Stall,
  output logic              MEM_AddrErr,
  output logic [31:0]       MEM_DMOut,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_DONE, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic        flushed;
  logic        accept;
  logic        access, start;
  logic        is_half, is_word;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic        lat_load;

  // Size code 3 is treated as a word everywhere, hence the test on bit 1 only.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size[1])      return d;
    else if (size[0]) return {2{d[15:0]}};
    else              return {4{d[7:0]}};
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] off);
    if (size[1])      return 4'b1111;
    else if (size[0]) return off[1] ? 4'b1100 : 4'b0011;
    else              return 4'b0001 << off;
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] off,
                                           input logic sign, input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    if (size[1])      return rd;
    else if (size[0]) return sign ? 32'($signed(h)) : {16'h0, h};
    else              return sign ? 32'($signed(b)) : {24'h0, b};
  endfunction

  assign access      = MEM_Valid & (MEM_IsLoad | MEM_IsStore);
  assign is_word     = MEM_Size[1];
  assign is_half     = (MEM_Size == 2'd1);
  assign MEM_AddrErr = access & ((is_half & MEM_Addr[0]) | (is_word & (MEM_Addr[1:0] != 2'b00)));
  assign start       = access & ~MEM_AddrErr & ~MEM_Flush;

  // The MEM stage is frozen while a request is pending, so bus fields come straight from it.
  assign data_wr    = MEM_IsStore;
  assign data_size  = MEM_Size;
  assign data_addr  = MEM_Addr;
  assign data_wdata = store_wdata(MEM_Size, MEM_StoreData);
  assign data_wstrb = MEM_IsStore ? store_wstrb(MEM_Size, MEM_Addr[1:0]) : 4'b0000;

  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    MEM_Stall = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        data_req  = start;
        MEM_Stall = start;
        if (start) begin
          accept    = data_addr_ok;
          state_nxt = data_addr_ok ? S_WAIT_DATA : S_REQ;
        end
      end
      S_REQ: begin
        data_req  = 1'b1;
        MEM_Stall = 1'b1;
        if (data_addr_ok) begin
          accept    = 1'b1;
          state_nxt = (flushed | MEM_Flush) ? S_DRAIN : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        MEM_Stall = 1'b1;
        if (data_data_ok)   state_nxt = MEM_Flush ? S_IDLE : S_DONE;
        else if (MEM_Flush) state_nxt = S_DRAIN;
      end
      S_DONE: begin
        if (WB_Wr | MEM_Flush) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        MEM_Stall = 1'b1;
        if (data_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      flushed   <= 1'b0;
      lat_off   <= 2'b00;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_load  <= 1'b0;
      MEM_DMOut <= 32'h0;
    end else begin
      state   <= state_nxt;
      flushed <= (state == S_REQ) & ~data_addr_ok & (flushed | MEM_Flush);
      if (accept) begin
        lat_off  <= MEM_Addr[1:0];
        lat_size <= MEM_Size;
        lat_sign <= MEM_LoadSign;
        lat_load <= MEM_IsLoad;
      end
      if ((state == S_WAIT_DATA) && data_data_ok && !MEM_Flush && lat_load)
        MEM_DMOut <= load_ext(lat_size, lat_off, lat_sign, data_rdata);
    end
  end

endmodule

// File: tb/tb_mem_dbus_master.sv
// Directed bench for mem_dbus_master: inputs change on the falling edge,
// outputs are checked 1ns later, well before the next rising edge.
module tb_mem_dbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Valid, MEM_IsLoad, MEM_IsStore;
  logic [31:0] MEM_Addr, MEM_StoreData;
  logic [1:0]  MEM_Size;
  logic        MEM_LoadSign, MEM_Flush, WB_Wr;
  logic        MEM_Stall, MEM_AddrErr;
  logic [31:0] MEM_DMOut;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int tests = 0;
  int fails = 0;

  mem_dbus_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_Valid(MEM_Valid), .MEM_IsLoad(MEM_IsLoad), .MEM_IsStore(MEM_IsStore),
    .MEM_Addr(MEM_Addr), .MEM_StoreData(MEM_StoreData), .MEM_Size(MEM_Size),
    .MEM_LoadSign(MEM_LoadSign), .MEM_Flush(MEM_Flush), .WB_Wr(WB_Wr),
    .MEM_Stall(MEM_Stall), .MEM_AddrErr(MEM_AddrErr), .MEM_DMOut(MEM_DMOut),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    MEM_Valid = 0; MEM_IsLoad = 0; MEM_IsStore = 0; MEM_Addr = 0; MEM_StoreData = 0;
    MEM_Size = 0; MEM_LoadSign = 0; MEM_Flush = 0; WB_Wr = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic go_idle();
    tick(); clear_inputs(); #1;
  endtask

  task automatic set_op(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] sd);
    MEM_Valid = 1; MEM_IsLoad = ld; MEM_IsStore = ~ld; MEM_Addr = a;
    MEM_Size = sz; MEM_LoadSign = sg; MEM_StoreData = sd; WB_Wr = 0;
  endtask

  // Load with addr_ok in cycle 0 and data_ok in cycle 1; returns inside the DONE cycle.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] rd);
    tick(); set_op(1, a, sz, sg, 0); data_addr_ok = 1;
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
    tick(); data_data_ok = 0; WB_Wr = 1; #1;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    repeat (2) tick();
    #1;
    tests++; if (data_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", data_req); end
    tests++; if (MEM_Stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", MEM_Stall); end
    tests++; if (MEM_DMOut !== 32'h0) begin fails++; $display("FAIL reset_dmout got %h want 0", MEM_DMOut); end
    tick(); rst = 0;
  endtask

  task automatic test_load_word();
    tick(); set_op(1, 32'h1000, 2, 0, 0); data_addr_ok = 1; #1;
    tests++; if (data_req !== 1'b1 || data_wr !== 1'b0 || data_wstrb !== 4'b0000 || data_addr !== 32'h1000)
      begin fails++; $display("FAIL lw_issue got req=%0b wr=%0b strb=%b addr=%h want 1 0 0000 1000", data_req, data_wr, data_wstrb, data_addr); end
    tests++; if (MEM_Stall !== 1'b1) begin fails++; $display("FAIL lw_stall_c0 got %0b want 1", MEM_Stall); end
    tick(); data_addr_ok = 0; #1;
    tests++; if (data_req !== 1'b0 || MEM_Stall !== 1'b1)
      begin fails++; $display("FAIL lw_c1 got req=%0b stall=%0b want 0 1", data_req, MEM_Stall); end
    tick(); data_data_ok = 1; data_rdata = 32'hDEADBEEF; #1;
    tests++; if (MEM_Stall !== 1'b1) begin fails++; $display("FAIL lw_stall_c2 got %0b want 1", MEM_Stall); end
    tick(); data_data_ok = 0; WB_Wr = 1; #1;
    tests++; if (MEM_Stall !== 1'b0 || MEM_DMOut !== 32'hDEADBEEF)
      begin fails++; $display("FAIL lw_c3 got stall=%0b dmout=%h want 0 deadbeef", MEM_Stall, MEM_DMOut); end
    go_idle();
  endtask

  task automatic test_load_ext();
    logic [31:0] addr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1001, 32'h1000};
    logic [1:0]  size [5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    logic        sign [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] rdat [5] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h1234ABCD};
    logic [31:0] expd [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00000022, 32'hFFFFABCD};
    for (int i = 0; i < 5; i++) begin
      do_load(addr[i], size[i], sign[i], rdat[i]);
      tests++; if (MEM_DMOut !== expd[i] || MEM_Stall !== 1'b0)
        begin fails++; $display("FAIL load_ext[%0d] got dmout=%h stall=%0b want %h 0", i, MEM_DMOut, MEM_Stall, expd[i]); end
      go_idle();
    end
  endtask

  task automatic test_store();
    tick(); set_op(0, 32'h2002, 1, 0, 32'h0000ABCD); data_addr_ok = 1; #1;
    tests++; if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd1 || data_wdata !== 32'hABCDABCD || data_wstrb !== 4'b1100)
      begin fails++; $display("FAIL sh_bus got req=%0b wr=%0b size=%0d wdata=%h strb=%b want 1 1 1 abcdabcd 1100", data_req, data_wr, data_size, data_wdata, data_wstrb); end
    tick(); data_addr_ok = 0; data_data_ok = 1; #1;
    tests++; if (data_req !== 1'b0 || MEM_Stall !== 1'b1)
      begin fails++; $display("FAIL sh_wait got req=%0b stall=%0b want 0 1", data_req, MEM_Stall); end
    tick(); data_data_ok = 0; WB_Wr = 1; #1;
    tests++; if (MEM_Stall !== 1'b0 || MEM_DMOut !== 32'hFFFFABCD)
      begin fails++; $display("FAIL sh_done got stall=%0b dmout=%h want 0 ffffabcd", MEM_Stall, MEM_DMOut); end
    go_idle();
    tick(); set_op(0, 32'h2001, 0, 0, 32'h12345677); #1;
    tests++; if (data_wdata !== 32'h77777777 || data_wstrb !== 4'b0010 || data_req !== 1'b1)
      begin fails++; $display("FAIL sb_bus got wdata=%h strb=%b req=%0b want 77777777 0010 1", data_wdata, data_wstrb, data_req); end
    MEM_Addr = 32'h2004; MEM_Size = 2; #1;
    tests++; if (data_wdata !== 32'h12345677 || data_wstrb !== 4'b1111)
      begin fails++; $display("FAIL sw_bus got wdata=%h strb=%b want 12345677 1111", data_wdata, data_wstrb); end
    MEM_Valid = 0;
    go_idle();
  endtask

  task automatic test_addr_err();
    tick(); set_op(1, 32'h1001, 2, 0, 0); data_addr_ok = 1; #1;
    tests++; if (MEM_AddrErr !== 1'b1 || data_req !== 1'b0 || MEM_Stall !== 1'b0)
      begin fails++; $display("FAIL lw_misalign got err=%0b req=%0b stall=%0b want 1 0 0", MEM_AddrErr, data_req, MEM_Stall); end
    MEM_Addr = 32'h1003; MEM_Size = 1; #1;
    tests++; if (MEM_AddrErr !== 1'b1 || data_req !== 1'b0)
      begin fails++; $display("FAIL lh_misalign got err=%0b req=%0b want 1 0", MEM_AddrErr, data_req); end
    MEM_Size = 0; #1;
    tests++; if (MEM_AddrErr !== 1'b0 || data_req !== 1'b1)
      begin fails++; $display("FAIL lb_aligned got err=%0b req=%0b want 0 1", MEM_AddrErr, data_req); end
    MEM_Valid = 0;
    go_idle();
  endtask

  task automatic test_flush_wait();
    tick(); set_op(1, 32'h1000, 2, 0, 0); data_addr_ok = 1;
    tick(); data_addr_ok = 0; MEM_Flush = 1; #1;
    tests++; if (MEM_Stall !== 1'b1) begin fails++; $display("FAIL flw_flush_stall got %0b want 1", MEM_Stall); end
    tick(); MEM_Flush = 0; set_op(1, 32'h1100, 2, 0, 0); data_addr_ok = 1; #1;
    tests++; if (data_req !== 1'b0 || MEM_Stall !== 1'b1)
      begin fails++; $display("FAIL flw_drain got req=%0b stall=%0b want 0 1", data_req, MEM_Stall); end
    tick(); data_addr_ok = 0; MEM_Valid = 0; #1;
    tests++; if (MEM_Stall !== 1'b1) begin fails++; $display("FAIL flw_drain2 got %0b want 1", MEM_Stall); end
    tick(); data_data_ok = 1; data_rdata = 32'h00001234; #1;
    tests++; if (MEM_Stall !== 1'b1) begin fails++; $display("FAIL flw_dataok got %0b want 1", MEM_Stall); end
    tick(); data_data_ok = 0; #1;
    tests++; if (MEM_Stall !== 1'b0 || data_req !== 1'b0 || MEM_DMOut !== 32'hFFFFABCD)
      begin fails++; $display("FAIL flw_end got stall=%0b req=%0b dmout=%h want 0 0 ffffabcd", MEM_Stall, data_req, MEM_DMOut); end
    tick(); set_op(1, 32'h1000, 2, 0, 0); data_addr_ok = 1;
    tick(); data_addr_ok = 0; data_data_ok = 1; MEM_Flush = 1; data_rdata = 32'h55555555;
    tick(); clear_inputs(); #1;
    tests++; if (MEM_Stall !== 1'b0 || MEM_DMOut !== 32'hFFFFABCD)
      begin fails++; $display("FAIL fl_with_dataok got stall=%0b dmout=%h want 0 ffffabcd", MEM_Stall, MEM_DMOut); end
  endtask

  task automatic test_flush_req();
    tick(); set_op(1, 32'h1000, 2, 0, 0);
    tick(); MEM_Flush = 1; #1;
    tests++; if (data_req !== 1'b1) begin fails++; $display("FAIL flr_hold got req=%0b want 1", data_req); end
    tick(); MEM_Flush = 0; data_addr_ok = 1; #1;
    tests++; if (data_req !== 1'b1) begin fails++; $display("FAIL flr_accept got req=%0b want 1", data_req); end
    tick(); data_addr_ok = 0; MEM_Valid = 0; #1;
    tests++; if (data_req !== 1'b0 || MEM_Stall !== 1'b1)
      begin fails++; $display("FAIL flr_drain got req=%0b stall=%0b want 0 1", data_req, MEM_Stall); end
    tick(); data_data_ok = 1; data_rdata = 32'h77777777;
    tick(); data_data_ok = 0; #1;
    tests++; if (MEM_Stall !== 1'b0 || MEM_DMOut !== 32'hFFFFABCD)
      begin fails++; $display("FAIL flr_end got stall=%0b dmout=%h want 0 ffffabcd", MEM_Stall, MEM_DMOut); end
  endtask

  task automatic test_addr_ok_stall();
    tick(); set_op(0, 32'h3000, 2, 0, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      #1;
      tests++; if (data_req !== 1'b1 || data_addr !== 32'h3000 || data_wdata !== 32'hCAFEF00D || MEM_Stall !== 1'b1)
        begin fails++; $display("FAIL req_stable[%0d] got req=%0b addr=%h wdata=%h stall=%0b", i, data_req, data_addr, data_wdata, MEM_Stall); end
    end
    tick(); data_addr_ok = 1;
    tick(); data_addr_ok = 0; data_data_ok = 1;
    tick(); data_data_ok = 0; #1;
    tests++; if (MEM_Stall !== 1'b0) begin fails++; $display("FAIL done_stall got %0b want 0", MEM_Stall); end
    tick(); #1;
    tests++; if (MEM_Stall !== 1'b0 || data_req !== 1'b0 || MEM_DMOut !== 32'hFFFFABCD)
      begin fails++; $display("FAIL done_hold got stall=%0b req=%0b dmout=%h want 0 0 ffffabcd", MEM_Stall, data_req, MEM_DMOut); end
    tick(); WB_Wr = 1;
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_load(32'h4000, 2, 0, 32'h11112222);
    tests++; if (MEM_DMOut !== 32'h11112222)
      begin fails++; $display("FAIL b2b_first got %h want 11112222", MEM_DMOut); end
    do_load(32'h4006, 1, 0, 32'h9999AAAA);
    tests++; if (MEM_DMOut !== 32'h00009999 || MEM_Stall !== 1'b0)
      begin fails++; $display("FAIL b2b_second got dmout=%h stall=%0b want 00009999 0", MEM_DMOut, MEM_Stall); end
    go_idle();
  endtask

  task automatic test_reset_in_req();
    tick(); set_op(1, 32'h5000, 2, 0, 0);
    tick(); #1;
    tests++; if (data_req !== 1'b1) begin fails++; $display("FAIL rreq_pending got %0b want 1", data_req); end
    #1; rst = 1; MEM_Valid = 0; #1;
    tests++; if (data_req !== 1'b0 || MEM_Stall !== 1'b0 || MEM_DMOut !== 32'h0)
      begin fails++; $display("FAIL rreq_reset got req=%0b stall=%0b dmout=%h want 0 0 0", data_req, MEM_Stall, MEM_DMOut); end
    tick(); rst = 0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_addr_err();
    test_flush_wait();
    test_flush_req();
    test_addr_ok_stall();
    test_back_to_back();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
